// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: runs one complete I2C transfer (address, optional register
// byte, data bytes, stop) by issuing command strobes to i2c_master_byte_ctrl.
// Optional feature macro: I2C_SEQ_REGADDR_EN adds a register-address phase
// (writes: addr, reg, data; reads: addr+W, reg, repeated start, addr+R, data).
module i2c_xfer_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_rnw_i,
  input  logic [6:0]       req_addr_i,
  input  logic [7:0]       req_reg_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [7:0]       wdata_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  output logic [7:0]       rdata_o,
  output logic             rdata_valid_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic             busy_o,
  output logic             start_o,
  output logic             stop_o,
  output logic             read_o,
  output logic             write_o,
  output logic             ack_o,
  output logic [7:0]       dat_o,
  input  logic             cmd_ack_i,
  input  logic             ack_i,
  input  logic [7:0]       dat_i,
  input  logic             al_i
);

  typedef enum logic [2:0] {
    IDLE, ADDR, REG, RADDR, WDAT, RDAT, STOP, DONE
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             ack_q, ack_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             done_q, done_d;
  logic [1:0]       err_out_q, err_out_d;
  logic             outstanding;
  logic             cmd_done;
  logic             rnw_eff_req;
  logic             rnw_eff_lat;

`ifdef I2C_SEQ_REGADDR_EN
  logic [7:0]       regaddr_q, regaddr_d;
  assign rnw_eff_req = 1'b0;
  assign rnw_eff_lat = 1'b0;
`else
  logic             unused_req_reg;
  assign unused_req_reg = ^req_reg_i;
  assign rnw_eff_req = req_rnw_i;
  assign rnw_eff_lat = rnw_q;
`endif

  // A command is outstanding while any strobe is held; only its ack counts.
  assign outstanding = start_q | stop_q | read_q | write_q;
  assign cmd_done    = cmd_ack_i & outstanding;

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign wdata_ready_o = (state_q == WDAT) & ~outstanding;
  assign start_o       = start_q;
  assign stop_o        = stop_q;
  assign read_o        = read_q;
  assign write_o       = write_q;
  assign ack_o         = ack_q;
  assign dat_o         = dat_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign done_o        = done_q;
  assign err_o         = err_out_q;

  // Next-state logic: each phase raises its strobes when idle, clears them on ack.
  always_comb begin
    state_d       = state_q;
    rnw_d         = rnw_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    start_d       = start_q;
    stop_d        = stop_q;
    read_d        = read_q;
    write_d       = write_q;
    ack_d         = ack_q;
    dat_d         = dat_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    err_out_d     = 2'd0;
`ifdef I2C_SEQ_REGADDR_EN
    regaddr_d     = regaddr_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rnw_d   = req_rnw_i;
          addr_d  = req_addr_i;
          cnt_d   = req_len_i;
          err_d   = 2'd0;
          start_d = 1'b1;
          write_d = 1'b1;
          dat_d   = {req_addr_i, rnw_eff_req};
`ifdef I2C_SEQ_REGADDR_EN
          regaddr_d = req_reg_i;
`endif
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (!outstanding) begin
          start_d = 1'b1;
          write_d = 1'b1;
          dat_d   = {addr_q, rnw_eff_lat};
        end else if (cmd_done) begin
          start_d = 1'b0;
          write_d = 1'b0;
          if (ack_i) begin
            err_d   = 2'd1;
            state_d = STOP;
          end else if (cnt_q == '0) begin
            state_d = STOP;
          end else begin
`ifdef I2C_SEQ_REGADDR_EN
            state_d = REG;
`else
            state_d = rnw_q ? RDAT : WDAT;
`endif
          end
        end
      end

`ifdef I2C_SEQ_REGADDR_EN
      REG: begin
        if (!outstanding) begin
          write_d = 1'b1;
          dat_d   = regaddr_q;
        end else if (cmd_done) begin
          write_d = 1'b0;
          if (ack_i) begin
            err_d   = 2'd2;
            state_d = STOP;
          end else begin
            state_d = rnw_q ? RADDR : WDAT;
          end
        end
      end

      RADDR: begin
        if (!outstanding) begin
          start_d = 1'b1;
          write_d = 1'b1;
          dat_d   = {addr_q, 1'b1};
        end else if (cmd_done) begin
          start_d = 1'b0;
          write_d = 1'b0;
          if (ack_i) begin
            err_d   = 2'd1;
            state_d = STOP;
          end else begin
            state_d = RDAT;
          end
        end
      end
`endif

      WDAT: begin
        if (!outstanding) begin
          if (wdata_valid_i) begin
            write_d = 1'b1;
            dat_d   = wdata_i;
          end
        end else if (cmd_done) begin
          write_d = 1'b0;
          cnt_d   = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = STOP;
          end else if (ack_i) begin
            err_d   = 2'd2;
            state_d = STOP;
          end
        end
      end

      RDAT: begin
        if (!outstanding) begin
          read_d = 1'b1;
          ack_d  = (cnt_q == LEN_ONE);
        end else if (cmd_done) begin
          read_d        = 1'b0;
          ack_d         = 1'b0;
          rdata_d       = dat_i;
          rdata_valid_d = 1'b1;
          cnt_d         = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (!outstanding) begin
          stop_d = 1'b1;
        end else if (cmd_done) begin
          stop_d    = 1'b0;
          done_d    = 1'b1;
          err_out_d = err_q;
          state_d   = DONE;
        end
      end

      DONE: begin
        err_d   = 2'd0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (al_i && (state_q != IDLE) && (state_q != DONE)) begin
      start_d       = 1'b0;
      stop_d        = 1'b0;
      read_d        = 1'b0;
      write_d       = 1'b0;
      ack_d         = 1'b0;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      cnt_d         = cnt_q;
      err_d         = 2'd3;
      err_out_d     = 2'd3;
      done_d        = 1'b1;
      state_d       = DONE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rnw_q         <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      err_q         <= 2'd0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      ack_q         <= 1'b0;
      dat_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_out_q     <= 2'd0;
`ifdef I2C_SEQ_REGADDR_EN
      regaddr_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rnw_q         <= rnw_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      read_q        <= read_d;
      write_q       <= write_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_out_q     <= err_out_d;
`ifdef I2C_SEQ_REGADDR_EN
      regaddr_q     <= regaddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Testbench for i2c_xfer_seq: a byte-controller responder acks each command,
// logs the command stream and compares it against a table of transfers.
// Builds with or without I2C_SEQ_REGADDR_EN; expectations follow the macro.
module tb_i2c_xfer_seq;

  localparam logic [2:0] C_SW = 3'd1;
  localparam logic [2:0] C_W  = 3'd2;
  localparam logic [2:0] C_R  = 3'd3;
  localparam logic [2:0] C_P  = 3'd4;
  localparam logic [3:0] NONE = 4'hF;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       req_rnw_i = 1'b0;
  logic [6:0] req_addr_i = '0;
  logic [7:0] req_reg_i = '0;
  logic [7:0] req_len_i = '0;
  logic [7:0] wdata_i = '0;
  logic       wdata_valid_i = 1'b0;
  logic       wdata_ready_o;
  logic [7:0] rdata_o;
  logic       rdata_valid_o;
  logic       done_o;
  logic [1:0] err_o;
  logic       busy_o;
  logic       start_o, stop_o, read_o, write_o, ack_o;
  logic [7:0] dat_o;
  logic       cmd_ack_i = 1'b0;
  logic       ack_i = 1'b0;
  logic [7:0] dat_i = '0;
  logic       al_i = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic             rnw;
    logic [6:0]       addr;
    logic [7:0]       regb;
    logic [7:0]       len;
    logic [3:0][7:0]  wd;
    logic [3:0]       nackIdx;
    logic [3:0]       alIdx;
    logic [3:0]       nexp;
    logic [7:0][11:0] exp;
    logic [1:0]       expErr;
    logic [3:0]       expRd;
    logic [3:0]       expWr;
  } vec_t;

  vec_t vecs[7];

  i2c_xfer_seq #(.LEN_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rnw_i(req_rnw_i), .req_addr_i(req_addr_i), .req_reg_i(req_reg_i),
    .req_len_i(req_len_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .start_o(start_o), .stop_o(stop_o), .read_o(read_o), .write_o(write_o),
    .ack_o(ack_o), .dat_o(dat_o),
    .cmd_ack_i(cmd_ack_i), .ack_i(ack_i), .dat_i(dat_i), .al_i(al_i)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rnw, input logic [6:0] addr,
                               input logic [7:0] regb, input logic [7:0] len);
    req_rnw_i   = rnw;
    req_addr_i  = addr;
    req_reg_i   = regb;
    req_len_i   = len;
    req_valid_i = 1'b1;
  endtask

  task automatic addCmd(input int i, input logic [2:0] t, input logic a,
                        input logic [7:0] d);
    vecs[i].exp[vecs[i].nexp] = {t, a, d};
    vecs[i].nexp = vecs[i].nexp + 4'd1;
  endtask

  task automatic clearDrive();
    cmd_ack_i     = 1'b0;
    ack_i         = 1'b0;
    al_i          = 1'b0;
    wdata_valid_i = 1'b0;
  endtask

  function automatic logic [2:0] classify();
    case ({start_o, stop_o, read_o, write_o})
      4'b1001: classify = C_SW;
      4'b0001: classify = C_W;
      4'b0010: classify = C_R;
      4'b0100: classify = C_P;
      default: classify = 3'd7;
    endcase
  endfunction

  task automatic runVector(input int vi, input vec_t v);
    logic [7:0][11:0] got;
    logic [3:0][7:0]  rdv;
    int cmdN = 0, rdN = 0, wrN = 0, readsAcked = 0;
    int age = 0, curIdx = 0, lat = 1;
    logic inCmd = 1'b0, expectLow = 1'b0, expectDone = 1'b0, expectRd = 1'b0;
    logic doneSeen = 1'b0;
    logic [1:0] gotErr = 2'd0;
    logic [2:0] curType = 3'd0;
    got = '0;
    rdv = '0;

    @(negedge clk_i);
    applyStimulus(v.rnw, v.addr, v.regb, v.len);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput($sformatf("v%0d_addr_latency", vi), {start_o, write_o, busy_o}, 3'b111);

    for (int cyc = 0; cyc < 400 && !doneSeen; cyc++) begin
      clearDrive();
      if (expectDone) begin
        checkOutput($sformatf("v%0d_done_timing", vi), done_o, 1'b1);
        expectDone = 1'b0;
      end
      if (expectRd) begin
        checkOutput($sformatf("v%0d_rdata_timing", vi), rdata_valid_o, 1'b1);
        expectRd = 1'b0;
      end
      if (expectLow) begin
        checkOutput($sformatf("v%0d_strobe_clear", vi),
                    {start_o, stop_o, read_o, write_o, ack_o}, 5'b0);
        expectLow = 1'b0;
      end
      if (rdata_valid_o) begin
        if (rdN < 4) rdv[rdN] = rdata_o;
        rdN++;
      end
      if (done_o) begin
        doneSeen = 1'b1;
        gotErr   = err_o;
      end
      if (!inCmd && !doneSeen && (start_o | stop_o | read_o | write_o)) begin
        curType = classify();
        curIdx  = cmdN;
        if (cmdN < 8) got[cmdN] = {curType, ack_o, dat_o};
        cmdN++;
        inCmd = 1'b1;
        age   = 0;
        lat   = 1 + ((curIdx + vi) % 3);
      end
      if (inCmd) begin
        age++;
        if (age == lat) begin
          cmd_ack_i = 1'b1;
          ack_i     = (curIdx == int'(v.nackIdx));
          dat_i     = 8'hC0 + 8'(readsAcked);
          if (curType == C_R) readsAcked++;
          inCmd     = 1'b0;
          expectLow = 1'b1;
          if (curIdx == int'(v.alIdx)) begin
            al_i       = 1'b1;
            expectDone = 1'b1;
          end else if (curType == C_P) begin
            expectDone = 1'b1;
          end else if (curType == C_R) begin
            expectRd = 1'b1;
          end
        end
      end
      if (wdata_ready_o && wrN < int'(v.len) && wrN < 4) begin
        wdata_valid_i = 1'b1;
        wdata_i       = v.wd[wrN];
        wrN++;
      end
      @(negedge clk_i);
    end
    clearDrive();

    if (!doneSeen) begin
      checkOutput($sformatf("v%0d_done_timeout", vi), 32'd0, 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
    end else begin
      checkOutput($sformatf("v%0d_ready_after_done", vi), {req_ready_o, done_o}, 2'b10);
    end

    checkOutput($sformatf("v%0d_cmd_count", vi), cmdN, v.nexp);
    for (int j = 0; j < int'(v.nexp) && j < cmdN && j < 8; j++) begin
      if (v.exp[j][11:9] == C_R || v.exp[j][11:9] == C_P)
        checkOutput($sformatf("v%0d_cmd%0d", vi, j), got[j][11:8], v.exp[j][11:8]);
      else
        checkOutput($sformatf("v%0d_cmd%0d", vi, j), got[j], v.exp[j]);
    end
    checkOutput($sformatf("v%0d_err", vi), gotErr, v.expErr);
    checkOutput($sformatf("v%0d_rd_count", vi), rdN, v.expRd);
    for (int j = 0; j < int'(v.expRd) && j < rdN && j < 4; j++)
      checkOutput($sformatf("v%0d_rdata%0d", vi, j), rdv[j], 8'hC0 + 8'(j));
    checkOutput($sformatf("v%0d_wr_count", vi), wrN, v.expWr);
  endtask

  initial begin
    // Table of transfers and the command stream each must produce
    for (int i = 0; i < 7; i++) begin
      vecs[i] = '0;
      vecs[i].nackIdx = NONE;
      vecs[i].alIdx   = NONE;
      vecs[i].regb    = 8'h10;
    end
    // v0: write 0x50, A5 3C, all ACK
    vecs[0].addr = 7'h50; vecs[0].len = 8'd2;
    vecs[0].wd[0] = 8'hA5; vecs[0].wd[1] = 8'h3C; vecs[0].expWr = 4'd2;
    // v1: read 0x50, three bytes
    vecs[1].rnw = 1'b1; vecs[1].addr = 7'h50; vecs[1].len = 8'd3; vecs[1].expRd = 4'd3;
    // v2: probe with address NACK
    vecs[2].addr = 7'h50; vecs[2].nackIdx = 4'd0; vecs[2].expErr = 2'd1;
    // v3: write three bytes, NACK on the second
    vecs[3].addr = 7'h50; vecs[3].len = 8'd3; vecs[3].expErr = 2'd2; vecs[3].expWr = 4'd2;
    vecs[3].wd[0] = 8'hA1; vecs[3].wd[1] = 8'hB2; vecs[3].wd[2] = 8'hC3;
    // v4: read three bytes, arbitration lost with the second read ack
    vecs[4].rnw = 1'b1; vecs[4].addr = 7'h50; vecs[4].len = 8'd3;
    vecs[4].expErr = 2'd3; vecs[4].expRd = 4'd1;
    // v5: single-byte write NACKed on the final byte (not an error)
    vecs[5].addr = 7'h2A; vecs[5].len = 8'd1; vecs[5].wd[0] = 8'h77; vecs[5].expWr = 4'd1;
    vecs[5].regb = 8'h33;
    // v6: write with address NACK, no data requested
    vecs[6].addr = 7'h3C; vecs[6].len = 8'd2; vecs[6].nackIdx = 4'd0; vecs[6].expErr = 2'd1;
    vecs[6].wd[0] = 8'h11; vecs[6].wd[1] = 8'h22;

`ifdef I2C_SEQ_REGADDR_EN
    addCmd(0, C_SW, 0, 8'hA0); addCmd(0, C_W, 0, 8'h10); addCmd(0, C_W, 0, 8'hA5);
    addCmd(0, C_W, 0, 8'h3C); addCmd(0, C_P, 0, 8'h00);
    addCmd(1, C_SW, 0, 8'hA0); addCmd(1, C_W, 0, 8'h10); addCmd(1, C_SW, 0, 8'hA1);
    addCmd(1, C_R, 0, 8'h00); addCmd(1, C_R, 0, 8'h00); addCmd(1, C_R, 1, 8'h00);
    addCmd(1, C_P, 0, 8'h00);
    addCmd(2, C_SW, 0, 8'hA0); addCmd(2, C_P, 0, 8'h00);
    vecs[3].nackIdx = 4'd3;
    addCmd(3, C_SW, 0, 8'hA0); addCmd(3, C_W, 0, 8'h10); addCmd(3, C_W, 0, 8'hA1);
    addCmd(3, C_W, 0, 8'hB2); addCmd(3, C_P, 0, 8'h00);
    vecs[4].alIdx = 4'd4;
    addCmd(4, C_SW, 0, 8'hA0); addCmd(4, C_W, 0, 8'h10); addCmd(4, C_SW, 0, 8'hA1);
    addCmd(4, C_R, 0, 8'h00); addCmd(4, C_R, 0, 8'h00);
    vecs[5].nackIdx = 4'd2;
    addCmd(5, C_SW, 0, 8'h54); addCmd(5, C_W, 0, 8'h33); addCmd(5, C_W, 0, 8'h77);
    addCmd(5, C_P, 0, 8'h00);
`else
    addCmd(0, C_SW, 0, 8'hA0); addCmd(0, C_W, 0, 8'hA5); addCmd(0, C_W, 0, 8'h3C);
    addCmd(0, C_P, 0, 8'h00);
    addCmd(1, C_SW, 0, 8'hA1); addCmd(1, C_R, 0, 8'h00); addCmd(1, C_R, 0, 8'h00);
    addCmd(1, C_R, 1, 8'h00); addCmd(1, C_P, 0, 8'h00);
    addCmd(2, C_SW, 0, 8'hA0); addCmd(2, C_P, 0, 8'h00);
    vecs[3].nackIdx = 4'd2;
    addCmd(3, C_SW, 0, 8'hA0); addCmd(3, C_W, 0, 8'hA1); addCmd(3, C_W, 0, 8'hB2);
    addCmd(3, C_P, 0, 8'h00);
    vecs[4].alIdx = 4'd2;
    addCmd(4, C_SW, 0, 8'hA1); addCmd(4, C_R, 0, 8'h00); addCmd(4, C_R, 0, 8'h00);
    vecs[5].nackIdx = 4'd1;
    addCmd(5, C_SW, 0, 8'h54); addCmd(5, C_W, 0, 8'h77); addCmd(5, C_P, 0, 8'h00);
`endif
    addCmd(6, C_SW, 0, 8'h78); addCmd(6, C_P, 0, 8'h00);

    // Reset state
    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs",
                {start_o, stop_o, read_o, write_o, ack_o, done_o, rdata_valid_o,
                 busy_o, wdata_ready_o, err_o, dat_o, rdata_o}, 27'd0);
    checkOutput("reset_ready", req_ready_o, 1'b1);
    rst_i = 1'b0;
    @(negedge clk_i);

    // cmd_ack in IDLE has no effect
    cmd_ack_i = 1'b1; ack_i = 1'b1;
    @(negedge clk_i);
    clearDrive();
    checkOutput("idle_ack_ignored",
                {busy_o, req_ready_o, done_o, start_o, stop_o, read_o, write_o}, 7'b0100000);

    for (int i = 0; i < 7; i++) runVector(i, vecs[i]);

    // Mid-WDAT reset while write data is withheld
    @(negedge clk_i);
    applyStimulus(1'b0, 7'h50, 8'h10, 8'd2);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int k = 0; k < 40 && !wdata_ready_o; k++) begin
      cmd_ack_i = start_o | stop_o | read_o | write_o;
      ack_i     = 1'b0;
      @(negedge clk_i);
    end
    clearDrive();
    checkOutput("stall_ready", wdata_ready_o, 1'b1);
    repeat (4) @(negedge clk_i);
    checkOutput("stall_no_cmd", {start_o, stop_o, read_o, write_o, wdata_ready_o, busy_o},
                6'b000011);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midreset_outputs",
                {start_o, stop_o, read_o, write_o, ack_o, done_o, rdata_valid_o,
                 busy_o, wdata_ready_o, err_o}, 11'd0);
    checkOutput("midreset_ready", req_ready_o, 1'b1);

    // A new request after the reset completes normally
    runVector(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
